// File: rtl/ppu_hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the RUN/WAIT state encoding, the forwarding-select codes, the
// memory-wait limit and a small helper that decides whether one pipeline
// stage's register-file write hits a given source register.
package ppu_hazard_pkg;

  // Controller state: RUN is normal flow, WAIT holds the whole pipe
  // until the data memory answers.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } hz_state_e;

  // Operand source select codes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Memory-wait counter width and the count at which the timeout flag sets.
  localparam int unsigned WAIT_CNT_W = 8;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = 8'd255;

  // Register-file write port of one pipeline stage.
  typedef struct packed {
    logic       en;
    logic [4:0] rd;
  } wr_port_t;

  // r0 is hard-wired to zero, so a write to it never produces a usable value.
  function automatic logic rd_hit(input wr_port_t wr, input logic [4:0] src);
    return wr.en && (wr.rd != 5'd0) && (wr.rd == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Purpose: per-operand forwarding select, priority EX > MEM > WB.
// Latency: purely combinational, same-cycle result.
// Backpressure: none; the caller decides whether a match must stall.
//
// Ports:
//   src_i      source register number of the ID operand
//   ex_i       EX stage write port  (en, rd)
//   mem_i      MEM stage write port (en, rd)
//   wb_i       WB stage write port  (en, rd)
//   ex_load_i  EX instruction is a load (its data is not available yet)
//   sel_o      operand source: FWD_RF / FWD_EX / FWD_MEM / FWD_WB
//   match_o    any stage writes this source, EX loads included
module hazard_fwd_sel
  import ppu_hazard_pkg::*;
(
  input  logic [4:0] src_i,
  input  wr_port_t   ex_i,
  input  wr_port_t   mem_i,
  input  wr_port_t   wb_i,
  input  logic       ex_load_i,
  output logic [1:0] sel_o,
  output logic       match_o
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = rd_hit(ex_i, src_i);
  assign mem_hit = rd_hit(mem_i, src_i);
  assign wb_hit  = rd_hit(wb_i, src_i);

  // match_o ignores the load exclusion: a pending load is still a
  // dependency, it just cannot be satisfied from EX.
  assign match_o = ex_hit | mem_hit | wb_hit;

  // A load in EX is skipped rather than blocking the chain; the select may
  // then point at an older MEM/WB value, but the load-use bubble issued in
  // the same cycle keeps that operand from being consumed.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit && !ex_load_i) begin
      sel_o = FWD_EX;
    end else if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: load-use / memory-wait stall control and operand forwarding.
// Latency: enables and selects are combinational (same cycle); state,
//          wait counter and timeout flag update on the rising clk edge.
// Backpressure: mem_req & !mem_ready freezes every pipeline register until
//          mem_ready; a load-use hazard freezes PC/nPC/IF-ID for one cycle
//          and injects a NOP.
//
// Build option: define PIPELINE_FORWARDING_EN to enable the forwarding
// network. Without it fwd_a/fwd_b stay 00 and every register dependency on
// EX/MEM/WB is resolved by repeated one-cycle bubbles.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rs/rt         ID source registers and their use
//   ex_rd, mem_rd, wb_rd, *_rf_enable   destination of each later stage
//   ex_load_instr                       EX instruction is a load
//   mem_req, mem_ready                  data memory handshake
//   pc_le, npc_le, if_le, pipe_le       pipeline register load enables
//   cu_mux_sel                          1 = inject NOP control word
//   fwd_a, fwd_b                        operand source selects
//   mem_timeout                         sticky memory-wait overrun flag
module pipeline_hazard_ctrl
  import ppu_hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       ex_rf_enable,
  input  logic       mem_rf_enable,
  input  logic       wb_rf_enable,
  input  logic       ex_load_instr,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_le,
  output logic       npc_le,
  output logic       if_le,
  output logic       pipe_le,
  output logic       cu_mux_sel,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout
);

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q, mem_timeout_d;

  wr_port_t ex_wr, mem_wr, wb_wr;
  logic [1:0] sel_a, sel_b;
  logic       match_a, match_b;
  logic       load_use;
  logic       bubble;
  logic       mem_stall;
  logic       front_le;
  logic       back_le;
  logic       nop_sel;

  assign ex_wr  = {ex_rf_enable, ex_rd};
  assign mem_wr = {mem_rf_enable, mem_rd};
  assign wb_wr  = {wb_rf_enable, wb_rd};

  hazard_fwd_sel u_fwd_a (
    .src_i     (id_rs),
    .ex_i      (ex_wr),
    .mem_i     (mem_wr),
    .wb_i      (wb_wr),
    .ex_load_i (ex_load_instr),
    .sel_o     (sel_a),
    .match_o   (match_a)
  );

  hazard_fwd_sel u_fwd_b (
    .src_i     (id_rt),
    .ex_i      (ex_wr),
    .mem_i     (mem_wr),
    .wb_i      (wb_wr),
    .ex_load_i (ex_load_instr),
    .sel_o     (sel_b),
    .match_o   (match_b)
  );

  // Loaded data only exists after MEM, so a consumer right behind the load
  // must slip one cycle and then pick the value up from MEM.
  assign load_use = ex_load_instr & ex_rf_enable & (ex_rd != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_rd)) |
                     (id_uses_rt & (id_rt == ex_rd)));

  assign mem_stall = mem_req & ~mem_ready;

`ifdef PIPELINE_FORWARDING_EN
  assign bubble = load_use;
  assign fwd_a  = reset ? FWD_RF : sel_a;
  assign fwd_b  = reset ? FWD_RF : sel_b;
`else
  // No bypass network: any in-flight write to a used source stalls ID until
  // the producer has retired through WB.
  logic unused_fwd_sel;
  assign unused_fwd_sel = ^{sel_a, sel_b};
  assign bubble = load_use | (id_uses_rs & match_a) | (id_uses_rt & match_b);
  assign fwd_a  = FWD_RF;
  assign fwd_b  = FWD_RF;
`endif

  // Enables and next state. Reset overrides the enables so the pipe keeps
  // flushing forward while the controller itself is being reset.
  always_comb begin
    front_le      = 1'b1;
    back_le       = 1'b1;
    nop_sel       = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          // The memory stall wins over load-use: nothing moves at all.
          if (mem_stall) begin
            front_le   = 1'b0;
            back_le    = 1'b0;
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end else if (bubble) begin
            front_le = 1'b0;
            nop_sel  = 1'b1;
          end
        end
        ST_WAIT: begin
          wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q
                                                  : wait_cnt_q + 8'd1;
          if (wait_cnt_d == WAIT_LIMIT) begin
            mem_timeout_d = 1'b1;
          end
          if (!mem_ready) begin
            front_le = 1'b0;
            back_le  = 1'b0;
          end else begin
            state_d = ST_RUN;
            // The ID instruction saw frozen EX/MEM contents during the wait;
            // its hazard is judged afresh in the release cycle.
            if (bubble) begin
              front_le = 1'b0;
              nop_sel  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_le      = front_le;
  assign npc_le     = front_le;
  assign if_le      = front_le;
  assign pipe_le    = back_le;
  assign cu_mux_sel = nop_sel;
  // Masked during reset so the flag reads clear from the first reset cycle.
  assign mem_timeout = mem_timeout_q & ~reset;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: self-checking bench for pipeline_hazard_ctrl.
// Latency: outputs sampled 2 time units after inputs change, mid-cycle.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

`ifdef PIPELINE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Control part of the expected word: {pc, npc, if, pipe, cu_mux_sel}
  localparam logic [4:0] C_RUN  = 5'b11110;
  localparam logic [4:0] C_BUB  = 5'b00011;
  localparam logic [4:0] C_HOLD = 5'b00000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt;
  logic       ex_rf_enable, mem_rf_enable, wb_rf_enable;
  logic       ex_load_instr, mem_req, mem_ready;
  logic       pc_le, npc_le, if_le, pipe_le, cu_mux_sel, mem_timeout;
  logic [1:0] fwd_a, fwd_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .ex_rd         (ex_rd),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .ex_rf_enable  (ex_rf_enable),
    .mem_rf_enable (mem_rf_enable),
    .wb_rf_enable  (wb_rf_enable),
    .ex_load_instr (ex_load_instr),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_le         (pc_le),
    .npc_le        (npc_le),
    .if_le         (if_le),
    .pipe_le       (pipe_le),
    .cu_mux_sel    (cu_mux_sel),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .mem_timeout   (mem_timeout)
  );

  typedef struct {
    string       name;
    logic [9:0]  exp;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    string      name;
    logic [4:0] rs, rt, exrd, memrd, wbrd;
    logic       urs, urt, exen, exld, memen, wben;
    logic [1:0] fa, fb;   // expected selects with forwarding built in
    logic       st_f;     // bubble expected with forwarding
    logic       st_nf;    // bubble expected without forwarding
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mkv(input string nm,
                               input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt,
                               input logic [4:0] exrd, input logic exen, input logic exld,
                               input logic [4:0] memrd, input logic memen,
                               input logic [4:0] wbrd, input logic wben,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic st_f, input logic st_nf);
    vec_t v;
    v.name = nm; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.exrd = exrd; v.exen = exen; v.exld = exld;
    v.memrd = memrd; v.memen = memen; v.wbrd = wbrd; v.wben = wben;
    v.fa = fa; v.fb = fb; v.st_f = st_f; v.st_nf = st_nf;
    return v;
  endfunction

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_rf_enable = 0; mem_rf_enable = 0; wb_rf_enable = 0;
    ex_load_instr = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_rs = v.rs; id_uses_rs = v.urs; id_rt = v.rt; id_uses_rt = v.urt;
    ex_rd = v.exrd; ex_rf_enable = v.exen; ex_load_instr = v.exld;
    mem_rd = v.memrd; mem_rf_enable = v.memen;
    wb_rd = v.wbrd; wb_rf_enable = v.wben;
  endtask

  // One clock cycle: queue the expectation for the inputs just driven,
  // sample mid-cycle, compare, then move past the next rising edge.
  task automatic cyc(input string nm, input logic [9:0] e);
    sb_t        it;
    logic [9:0] act;
    sb_q.push_back('{name: nm, exp: e});
    #2;
    act = {pc_le, npc_le, if_le, pipe_le, cu_mux_sel, fwd_a, fwd_b, mem_timeout};
    it  = sb_q.pop_front();
    checks++;
    if (act !== it.exp) begin
      failures++;
      $display("FAIL %s: got {le4,cu,fa,fb,to}=%b expected %b", it.name, act, it.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] efa, efb;
    logic       est;

    // Table of single-cycle RUN-state vectors (applied back to back, so
    // entries 0..2 also form the load / bubble / load-in-MEM sequence).
    //                 name               rs urs rt urt  ex en ld  mem en  wb en  fa     fb     stF stNF
    vecs[0]  = mkv("ex_fwd_rs",          5, 1, 0, 0,   5, 1, 0,  0, 0,  0, 0,  2'b01, 2'b00, 0, 1);
    vecs[1]  = mkv("load_use_bubble",    5, 1, 0, 0,   5, 1, 1,  0, 0,  0, 0,  2'b00, 2'b00, 1, 1);
    vecs[2]  = mkv("load_in_mem",        5, 1, 0, 0,   0, 0, 0,  5, 1,  0, 0,  2'b10, 2'b00, 0, 1);
    vecs[3]  = mkv("prio_ex_r7",         0, 0, 7, 1,   7, 1, 0,  7, 1,  7, 1,  2'b00, 2'b01, 0, 1);
    vecs[4]  = mkv("all_write_r0",       0, 1, 0, 1,   0, 1, 0,  0, 1,  0, 1,  2'b00, 2'b00, 0, 0);
    vecs[5]  = mkv("prio_mem_r7",        0, 0, 7, 1,   3, 1, 0,  7, 1,  7, 1,  2'b00, 2'b10, 0, 1);
    vecs[6]  = mkv("wb_only_r7",         0, 0, 7, 1,   3, 1, 0,  4, 1,  7, 1,  2'b00, 2'b11, 0, 1);
    vecs[7]  = mkv("load_skips_ex",      0, 0, 7, 1,   7, 1, 1,  7, 1,  0, 0,  2'b00, 2'b10, 1, 1);
    vecs[8]  = mkv("ex_no_rf_write",     5, 1, 0, 0,   5, 0, 0,  0, 0,  0, 0,  2'b00, 2'b00, 0, 0);
    vecs[9]  = mkv("load_src_unused",    5, 0, 0, 0,   5, 1, 1,  0, 0,  0, 0,  2'b00, 2'b00, 0, 0);
    vecs[10] = mkv("both_operands",      3, 1, 4, 1,   9, 1, 0,  3, 1,  4, 1,  2'b10, 2'b11, 0, 1);
    vecs[11] = mkv("load_to_r0",         0, 1, 0, 0,   0, 1, 1,  0, 0,  0, 0,  2'b00, 2'b00, 0, 0);
    vecs[12] = mkv("fwd_src_unused",     5, 0, 0, 0,   5, 1, 0,  0, 0,  0, 0,  2'b01, 2'b00, 0, 0);

    // Reset with a load-use hazard and a memory stall present: reset wins.
    idle_inputs();
    drive_vec(vecs[1]);
    mem_req = 1;
    reset   = 1;
    cyc("reset_outputs_0", {C_RUN, 2'b00, 2'b00, 1'b0});
    cyc("reset_outputs_1", {C_RUN, 2'b00, 2'b00, 1'b0});
    reset = 0;
    idle_inputs();
    cyc("idle_after_reset", {C_RUN, 2'b00, 2'b00, 1'b0});

    // Table-driven combinational checks in RUN.
    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      drive_vec(vecs[i]);
      efa = FWD ? vecs[i].fa : 2'b00;
      efb = FWD ? vecs[i].fb : 2'b00;
      est = FWD ? vecs[i].st_f : vecs[i].st_nf;
      cyc(vecs[i].name, {(est ? C_BUB : C_RUN), efa, efb, 1'b0});
    end

    // Memory stall: takes priority over load-use, holds for 3 cycles.
    idle_inputs();
    drive_vec(vecs[1]);
    mem_req = 1;
    cyc("memstall_over_loaduse", {C_HOLD, 2'b00, 2'b00, 1'b0});
    idle_inputs();
    mem_req = 1;
    cyc("wait_cycle_1", {C_HOLD, 2'b00, 2'b00, 1'b0});
    cyc("wait_cycle_2", {C_HOLD, 2'b00, 2'b00, 1'b0});
    mem_ready = 1;
    cyc("wait_release", {C_RUN, 2'b00, 2'b00, 1'b0});
    idle_inputs();
    cyc("run_after_release", {C_RUN, 2'b00, 2'b00, 1'b0});
    // Request completing in the same cycle is not a stall.
    mem_req = 1; mem_ready = 1;
    cyc("req_ready_same_cycle", {C_RUN, 2'b00, 2'b00, 1'b0});
    idle_inputs();
    cyc("still_run", {C_RUN, 2'b00, 2'b00, 1'b0});

    // Reset in the middle of a wait abandons it.
    mem_req = 1;
    cyc("rw_enter_wait", {C_HOLD, 2'b00, 2'b00, 1'b0});
    cyc("rw_waiting", {C_HOLD, 2'b00, 2'b00, 1'b0});
    reset = 1;
    cyc("rw_reset_in_wait", {C_RUN, 2'b00, 2'b00, 1'b0});
    reset = 0;
    idle_inputs();
    cyc("rw_run_after_reset", {C_RUN, 2'b00, 2'b00, 1'b0});

    // Long wait: cycle 0 is the RUN stall cycle, cycles 1..300 are WAIT.
    // The flag must be clear through WAIT cycle 255 and set from 256.
    idle_inputs();
    mem_req = 1;
    for (int c = 0; c <= 300; c++) begin
      cyc($sformatf("timeout_wait_c%0d", c), {C_HOLD, 2'b00, 2'b00, (c >= 256)});
    end
    checks++;
    if (dut.wait_cnt_q !== 8'd255) begin
      failures++;
      $display("FAIL wait_cnt_saturate: got %0d expected 255", dut.wait_cnt_q);
    end
    mem_ready = 1;
    cyc("timeout_release", {C_RUN, 2'b00, 2'b00, 1'b1});
    idle_inputs();
    cyc("timeout_sticky_0", {C_RUN, 2'b00, 2'b00, 1'b1});
    drive_vec(vecs[1]);
    cyc("timeout_sticky_bubble", {C_BUB, 2'b00, 2'b00, 1'b1});
    idle_inputs();
    cyc("timeout_sticky_1", {C_RUN, 2'b00, 2'b00, 1'b1});
    reset = 1;
    cyc("timeout_in_reset", {C_RUN, 2'b00, 2'b00, 1'b0});
    reset = 0;
    cyc("timeout_cleared", {C_RUN, 2'b00, 2'b00, 1'b0});

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained: got %0d entries expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
